// File: rtl/bert_meas_seq_if.sv
// Signal bundle between scan control / BERT checkers and the measurement sequencer.
// The slave side is the sequencer; the master side is scan config plus the BERT.
interface bert_meas_seq_if #(
    parameter int WayWidth = 16,
    parameter int CntWidth = 32
);
    logic                  i_start;
    logic                  i_abort;
    logic [2:0]            i_cfg_chk_mask;
    logic [WayWidth-1:0]   i_cfg_way_en;
    logic [15:0]           i_cfg_seed_timeout;
    logic [CntWidth-1:0]   i_cfg_meas_len;
    logic [3*WayWidth-1:0] i_prbs_seed_good;
    logic [2:0]            i_ber_shutoff;
    logic [3*CntWidth-1:0] i_ber_count;
    logic [3*CntWidth-1:0] i_bit_count;

    logic                  o_rst_bert;
    logic [WayWidth-1:0]   o_cfg_ber_count_en;
    logic [1:0]            o_chk_sel;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_aborted;
    logic [5:0]            o_status;
    logic [3*CntWidth-1:0] o_ber_count_lat;
    logic [3*CntWidth-1:0] o_bit_count_lat;

    modport master (
        output i_start, i_abort, i_cfg_chk_mask, i_cfg_way_en, i_cfg_seed_timeout,
               i_cfg_meas_len, i_prbs_seed_good, i_ber_shutoff, i_ber_count, i_bit_count,
        input  o_rst_bert, o_cfg_ber_count_en, o_chk_sel, o_busy, o_done, o_aborted,
               o_status, o_ber_count_lat, o_bit_count_lat
    );

    modport slave (
        input  i_start, i_abort, i_cfg_chk_mask, i_cfg_way_en, i_cfg_seed_timeout,
               i_cfg_meas_len, i_prbs_seed_good, i_ber_shutoff, i_ber_count, i_bit_count,
        output o_rst_bert, o_cfg_ber_count_en, o_chk_sel, o_busy, o_done, o_aborted,
               o_status, o_ber_count_lat, o_bit_count_lat
    );
endinterface

// File: rtl/bert_meas_seq.sv
// BERT measurement sequencer: walks PRBS7 -> PRBS15 -> PRBS31, per checker running
// reset, seed lock, a gated count window and settle, then latches counts and a result code.
module bert_meas_seq #(
    parameter int WayWidth     = 16,
    parameter int CntWidth     = 32,
    parameter int RstCycles    = 4,
    parameter int SettleCycles = 2
) (
    input logic            i_clk,
    input logic            i_rst_n,
    bert_meas_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_SEED   = 3'd2;
    localparam logic [2:0] S_COUNT  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_LATCH  = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int PhMax = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int PhW   = $clog2(PhMax + 1);
    localparam logic [PhW-1:0] RstLast    = PhW'(RstCycles - 1);
    localparam logic [PhW-1:0] SettleLast = PhW'(SettleCycles - 1);
    localparam logic [2:0]     AfterCount = (SettleCycles == 0) ? S_LATCH : S_SETTLE;

    logic [2:0]          state;
    logic                start_q;
    logic [2:0]          mask_q;
    logic [1:0]          sel;
    logic [PhW-1:0]      ph_cnt;
    logic [15:0]         seed_cnt;
    logic [CntWidth-1:0] win_cnt;
    logic                done_q;
    logic                aborted_q;
    logic [1:0]          status_a  [3];
    logic [CntWidth-1:0] ber_lat_a [3];
    logic [CntWidth-1:0] bit_lat_a [3];

    logic [WayWidth-1:0] seed_good_a [3];
    logic [CntWidth-1:0] ber_in_a    [3];
    logic [CntWidth-1:0] bit_in_a    [3];

    for (genvar k = 0; k < 3; k++) begin : g_unpack
        assign seed_good_a[k] = bus.i_prbs_seed_good[k*WayWidth +: WayWidth];
        assign ber_in_a[k]    = bus.i_ber_count[k*CntWidth +: CntWidth];
        assign bit_in_a[k]    = bus.i_bit_count[k*CntWidth +: CntWidth];
    end

    logic                start_rise;
    logic                seed_locked;
    logic [15:0]         seed_next;
    logic [CntWidth-1:0] win_next;
    logic [CntWidth-1:0] meas_eff;
    logic                in_seq;

    assign start_rise  = bus.i_start & ~start_q;
    assign seed_locked = (seed_good_a[sel] & bus.i_cfg_way_en) == bus.i_cfg_way_en;
    assign seed_next   = (seed_cnt == '1) ? seed_cnt : seed_cnt + 16'd1;
    assign win_next    = (win_cnt == '1) ? win_cnt : win_cnt + CntWidth'(1);
    assign meas_eff    = (bus.i_cfg_meas_len == '0) ? CntWidth'(1) : bus.i_cfg_meas_len;
    assign in_seq      = (state != S_IDLE) && (state != S_DONE);

    logic [1:0] first_chk;
    logic [1:0] next_chk;
    logic       next_found;

    // Lowest enabled checker at start, and the next higher enabled one after sel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        first_chk  = 2'd2;
        next_chk   = sel;
        next_found = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.i_cfg_chk_mask[k]) first_chk = 2'(k);
            if (mask_q[k] && (2'(k) > sel)) begin
                next_chk   = 2'(k);
                next_found = 1'b1;
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            mask_q    <= '0;
            sel       <= '0;
            ph_cnt    <= '0;
            seed_cnt  <= '0;
            win_cnt   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            // NOTE: the result arrays are tiny and drive outputs directly, so they are reset like any register.
            for (int k = 0; k < 3; k++) begin
                status_a[k]  <= '0;
                ber_lat_a[k] <= '0;
                bit_lat_a[k] <= '0;
            end
        end else begin
            start_q <= bus.i_start;
            if (in_seq && bus.i_abort) begin
                state     <= S_IDLE;
                aborted_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_rise && !bus.i_abort) begin
                            done_q    <= 1'b0;
                            aborted_q <= 1'b0;
                            mask_q    <= bus.i_cfg_chk_mask;
                            ph_cnt    <= '0;
                            for (int k = 0; k < 3; k++) begin
                                status_a[k]  <= '0;
                                ber_lat_a[k] <= '0;
                                bit_lat_a[k] <= '0;
                            end
                            if (bus.i_cfg_chk_mask == 3'b000) begin
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                sel   <= first_chk;
                                state <= S_RST;
                            end
                        end
                    end
                    S_RST: begin
                        if (ph_cnt == RstLast) begin
                            seed_cnt <= '0;
                            state    <= S_SEED;
                        end else begin
                            ph_cnt <= ph_cnt + PhW'(1);
                        end
                    end
                    S_SEED: begin
                        // Lock is tested ahead of the timeout so it wins a same-cycle tie.
                        if (seed_locked) begin
                            win_cnt <= '0;
                            state   <= S_COUNT;
                        end else if (seed_next >= bus.i_cfg_seed_timeout) begin
                            status_a[sel] <= 2'b11;
                            state         <= S_NEXT;
                        end else begin
                            seed_cnt <= seed_next;
                        end
                    end
                    S_COUNT: begin
                        if (bus.i_ber_shutoff[sel]) begin
                            status_a[sel] <= 2'b10;
                            ph_cnt        <= '0;
                            state         <= AfterCount;
                        end else if (win_next >= meas_eff) begin
                            status_a[sel] <= 2'b01;
                            ph_cnt        <= '0;
                            state         <= AfterCount;
                        end else begin
                            win_cnt <= win_next;
                        end
                    end
                    S_SETTLE: begin
                        if (ph_cnt == SettleLast) state <= S_LATCH;
                        else                      ph_cnt <= ph_cnt + PhW'(1);
                    end
                    S_LATCH: begin
                        ber_lat_a[sel] <= ber_in_a[sel];
                        bit_lat_a[sel] <= bit_in_a[sel];
                        state          <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (next_found) begin
                            sel    <= next_chk;
                            ph_cnt <= '0;
                            state  <= S_RST;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_rst_bert         = (state == S_RST);
    assign bus.o_cfg_ber_count_en = (state == S_COUNT) ? bus.i_cfg_way_en : '0;
    assign bus.o_chk_sel          = sel;
    assign bus.o_busy             = in_seq;
    assign bus.o_done             = done_q;
    assign bus.o_aborted          = aborted_q;
    assign bus.o_status           = {status_a[2], status_a[1], status_a[0]};
    assign bus.o_ber_count_lat    = {ber_lat_a[2], ber_lat_a[1], ber_lat_a[0]};
    assign bus.o_bit_count_lat    = {bit_lat_a[2], bit_lat_a[1], bit_lat_a[0]};
endmodule

// File: tb/tb_bert_meas_seq.sv
// Self-checking bench for bert_meas_seq: a behavioural BERT stub plus a phase-length
// reference model, directed corner cases and randomized sequences.
module tb_bert_meas_seq;
    localparam int WayWidth     = 16;
    localparam int CntWidth     = 32;
    localparam int RstCycles    = 4;
    localparam int SettleCycles = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    bert_meas_seq_if #(.WayWidth(WayWidth), .CntWidth(CntWidth)) bus ();

    bert_meas_seq #(
        .WayWidth(WayWidth), .CntWidth(CntWidth),
        .RstCycles(RstCycles), .SettleCycles(SettleCycles)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Stub behaviour per checker: lock after lock_d cycles out of reset (unless never),
    // shut off once count enable has been high for shut_at cycles.
    int                  lock_d  [3];
    bit                  never   [3];
    bit                  shut_en [3];
    int                  shut_at [3];
    logic [CntWidth-1:0] ber_v   [3];
    logic [CntWidth-1:0] bit_v   [3];
    int                  lowcnt = 0;
    int                  encnt  = 0;

    initial begin
        bus.i_prbs_seed_good = '0;
        bus.i_ber_shutoff    = '0;
        forever begin
            @(negedge clk);
            if (bus.o_rst_bert) lowcnt = 0; else lowcnt++;
            if (bus.o_cfg_ber_count_en != '0) encnt++; else encnt = 0;
            for (int k = 0; k < 3; k++) begin
                // Unlocked ways outside way_en are driven high so masking is exercised.
                if (!bus.o_rst_bert && !never[k] && lowcnt >= lock_d[k])
                    bus.i_prbs_seed_good[k*WayWidth +: WayWidth] = '1;
                else
                    bus.i_prbs_seed_good[k*WayWidth +: WayWidth] = ~bus.i_cfg_way_en;
                bus.i_ber_shutoff[k] = shut_en[k] && (encnt >= shut_at[k]);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] mask, input logic [15:0] way,
                           input logic [15:0] tmo, input logic [31:0] meas);
        bus.i_cfg_chk_mask     = mask;
        bus.i_cfg_way_en       = way;
        bus.i_cfg_seed_timeout = tmo;
        bus.i_cfg_meas_len     = meas;
        for (int k = 0; k < 3; k++) begin
            lock_d[k]  = 1;
            never[k]   = 1'b0;
            shut_en[k] = 1'b0;
            shut_at[k] = 1;
            ber_v[k]   = $urandom;
            bit_v[k]   = $urandom;
        end
    endtask

    task automatic drive_counts();
        bus.i_ber_count = {ber_v[2], ber_v[1], ber_v[0]};
        bus.i_bit_count = {bit_v[2], bit_v[1], bit_v[0]};
    endtask

    // One full sequence: model the expected phases, run it, compare.
    task automatic run_seq(input string name, input bit retrig);
        int                    exp_rst[$], exp_en[$], got_rst[$], got_en[$];
        int                    exp_busy, len_eff, teff, seed, w, cur_rst, cur_en, busy_cnt, cyc, post_busy;
        int                    exp_sel;
        bit                    locked, shut, saw_done;
        logic [5:0]            exp_status;
        logic [3*CntWidth-1:0] exp_ber, exp_bit;

        drive_counts();
        len_eff    = (bus.i_cfg_meas_len == 0) ? 1 : int'(bus.i_cfg_meas_len);
        teff       = (bus.i_cfg_seed_timeout == 0) ? 1 : int'(bus.i_cfg_seed_timeout);
        exp_busy   = 0;
        exp_status = '0;
        exp_ber    = '0;
        exp_bit    = '0;
        exp_sel    = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.i_cfg_chk_mask[k]) begin
                exp_sel = k;
                exp_rst.push_back(RstCycles);
                locked = (bus.i_cfg_way_en == 0) || (!never[k] && lock_d[k] <= teff);
                if (!locked) begin
                    exp_status[2*k +: 2] = 2'b11;
                    exp_busy += RstCycles + teff + 1;
                end else begin
                    seed = (bus.i_cfg_way_en == 0) ? 1 : lock_d[k];
                    shut = shut_en[k] && (shut_at[k] <= len_eff);
                    w    = shut ? shut_at[k] : len_eff;
                    exp_status[2*k +: 2] = shut ? 2'b10 : 2'b01;
                    if (bus.i_cfg_way_en != 0) exp_en.push_back(w);
                    exp_ber[k*CntWidth +: CntWidth] = ber_v[k];
                    exp_bit[k*CntWidth +: CntWidth] = bit_v[k];
                    exp_busy += RstCycles + seed + w + SettleCycles + 2;
                end
            end
        end

        bus.i_start = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        busy_cnt = 0; cur_rst = 0; cur_en = 0; saw_done = 1'b0;
        for (cyc = 1; cyc <= 6000; cyc++) begin
            @(negedge clk);
            if (retrig && cyc == 3) bus.i_start = 1'b0;
            if (retrig && cyc == 8) bus.i_start = 1'b1;
            if (bus.o_busy) busy_cnt++;
            if (bus.o_rst_bert) cur_rst++;
            else if (cur_rst != 0) begin got_rst.push_back(cur_rst); cur_rst = 0; end
            if (bus.o_cfg_ber_count_en != '0) begin
                cur_en++;
                check({name, "_en_value"}, bus.o_cfg_ber_count_en, bus.i_cfg_way_en);
            end else if (cur_en != 0) begin
                got_en.push_back(cur_en); cur_en = 0;
            end
            if (bus.o_done) begin saw_done = 1'b1; break; end
        end

        check({name, "_done"}, saw_done, 1'b1);
        if (bus.i_cfg_chk_mask == 3'b000) check({name, "_fast_done"}, cyc <= 2, 1'b1);
        else                              check({name, "_chk_sel"}, bus.o_chk_sel, exp_sel);
        check({name, "_busy_at_done"}, bus.o_busy, 1'b0);
        check({name, "_aborted"}, bus.o_aborted, 1'b0);
        check({name, "_status"}, bus.o_status, exp_status);
        check({name, "_ber_lat"}, bus.o_ber_count_lat, exp_ber);
        check({name, "_bit_lat"}, bus.o_bit_count_lat, exp_bit);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        check({name, "_rst_pulses"}, got_rst.size(), exp_rst.size());
        foreach (exp_rst[i]) check($sformatf("%s_rst_len%0d", name, i), got_rst[i], exp_rst[i]);
        check({name, "_en_windows"}, got_en.size(), exp_en.size());
        foreach (exp_en[i]) check($sformatf("%s_en_len%0d", name, i), got_en[i], exp_en[i]);

        post_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_busy) post_busy++;
        end
        check({name, "_no_rerun"}, post_busy, 0);
        check({name, "_done_sticky"}, bus.o_done, 1'b1);
        bus.i_start = 1'b0;
    endtask

    initial begin
        bit found;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        set_cfg(3'b000, 16'hFFFF, 16'd10, 32'd10);
        drive_counts();

        repeat (3) @(negedge clk);
        check("rst_busy",    bus.o_busy, 1'b0);
        check("rst_done",    bus.o_done, 1'b0);
        check("rst_aborted", bus.o_aborted, 1'b0);
        check("rst_status",  bus.o_status, 6'b0);
        check("rst_rstbert", bus.o_rst_bert, 1'b0);
        check("rst_en",      bus.o_cfg_ber_count_en, 16'h0);
        check("rst_sel",     bus.o_chk_sel, 2'd0);
        check("rst_ber_lat", bus.o_ber_count_lat, 96'h0);
        check("rst_bit_lat", bus.o_bit_count_lat, 96'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // All three pass, with a second start edge while busy.
        set_cfg(3'b111, 16'hFFFF, 16'd200, 32'd100);
        for (int k = 0; k < 3; k++) begin ber_v[k] = 5; bit_v[k] = 100; end
        run_seq("all_pass", 1'b1);

        set_cfg(3'b010, 16'hFFFF, 16'd50, 32'd20);
        never[1] = 1'b1;
        run_seq("seed_timeout", 1'b0);

        set_cfg(3'b001, 16'hFFFF, 16'd200, 32'd1000);
        shut_en[0] = 1'b1; shut_at[0] = 10;
        run_seq("shutoff", 1'b0);

        set_cfg(3'b000, 16'hFFFF, 16'd20, 32'd20);
        run_seq("mask_zero", 1'b0);

        set_cfg(3'b100, 16'h00F0, 16'd20, 32'd0);
        shut_en[2] = 1'b1; shut_at[2] = 1;
        run_seq("len0_shut", 1'b0);

        set_cfg(3'b011, 16'h0000, 16'd10, 32'd5);
        run_seq("way_zero", 1'b0);

        set_cfg(3'b011, 16'h0F0F, 16'd7, 32'd3);
        lock_d[0] = 7; lock_d[1] = 8;
        run_seq("lock_vs_tmo", 1'b0);

        // Abort during PRBS31 COUNT, then abort held in IDLE blocks a start edge.
        set_cfg(3'b101, 16'hFFFF, 16'd100, 32'd40);
        lock_d[0] = 2; lock_d[2] = 2;
        drive_counts();
        bus.i_start = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.o_chk_sel == 2'd2 && bus.o_cfg_ber_count_en != '0) begin found = 1'b1; break; end
        end
        check("abort_reach_count", found, 1'b1);
        repeat (3) @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        check("abort_busy",    bus.o_busy, 1'b0);
        check("abort_en",      bus.o_cfg_ber_count_en, 16'h0);
        check("abort_rstbert", bus.o_rst_bert, 1'b0);
        check("abort_flag",    bus.o_aborted, 1'b1);
        check("abort_done",    bus.o_done, 1'b0);
        check("abort_status",  bus.o_status, 6'b000001);
        check("abort_ber_lat", bus.o_ber_count_lat, {64'h0, ber_v[0]});
        check("abort_bit_lat", bus.o_bit_count_lat, {64'h0, bit_v[0]});
        bus.i_start = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_blocks_start", bus.o_busy, 1'b0);
        check("abort_sticky",       bus.o_aborted, 1'b1);
        bus.i_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("held_start_no_retrig", bus.o_busy, 1'b0);
        bus.i_start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_cfg(3'($urandom_range(1, 7)), 16'($urandom_range(1, 16'hFFFF)),
                    16'($urandom_range(3, 20)), 32'($urandom_range(0, 30)));
            for (int k = 0; k < 3; k++) begin
                lock_d[k]  = $urandom_range(1, 24);
                never[k]   = ($urandom_range(0, 3) == 0);
                shut_en[k] = ($urandom_range(0, 2) == 0);
                shut_at[k] = $urandom_range(1, 35);
            end
            run_seq($sformatf("rand%0d", i), 1'b0);
        end

        // Asynchronous reset in the middle of the second checker.
        set_cfg(3'b111, 16'hFFFF, 16'd100, 32'd20);
        drive_counts();
        bus.i_start = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        repeat (35) @(negedge clk);
        check("arst_pre_busy",    bus.o_busy, 1'b1);
        check("arst_pre_status",  bus.o_status, 6'b000001);
        check("arst_pre_ber_lat", bus.o_ber_count_lat[CntWidth-1:0], ber_v[0]);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",    bus.o_busy, 1'b0);
        check("arst_en",      bus.o_cfg_ber_count_en, 16'h0);
        check("arst_rstbert", bus.o_rst_bert, 1'b0);
        check("arst_status",  bus.o_status, 6'b0);
        check("arst_ber_lat", bus.o_ber_count_lat, 96'h0);
        check("arst_sel",     bus.o_chk_sel, 2'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bert_meas_seq.md
Name: bert_meas_seq

Overview:
- Hardware sequencer for the three BERT checkers (PRBS7, PRBS15, PRBS31) behind the DSP backend scan control.
- On one start request it walks the enabled checkers in fixed order PRBS7 → PRBS15 → PRBS31. For each checker it pulses BERT reset, waits for seed lock, gates error counting for a programmed window, then latches the counts and a result code.
- Sits between the scan config registers and the BERT; scan reads back latched results, so no scan-timing-dependent sampling is needed.

Parameters:
- WayWidth, 16, BERT ways per checker (width of way enable and seed-good).
- CntWidth, 32, width of ber/bit count per checker.
- RstCycles, 4, o_rst_bert pulse length in cycles (≥1).
- SettleCycles, 2, drain cycles after count_en drops, before latching.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_start  in  1  level from scan; rising edge starts a sequence
- i_abort  in  1  level; while high, forces return to IDLE
- i_cfg_chk_mask  in  3  checker enable, bit0=PRBS7, bit1=PRBS15, bit2=PRBS31
- i_cfg_way_en  in  WayWidth  ways that must lock and are counted
- i_cfg_seed_timeout  in  16  max SEED cycles per checker
- i_cfg_meas_len  in  CntWidth  COUNT window in cycles; 0 treated as 1
- i_prbs_seed_good  in  3*WayWidth  per-checker seed-good, checker k at slice [k*WayWidth +: WayWidth]
- i_ber_shutoff  in  3  per-checker shutoff flag
- i_ber_count  in  3*CntWidth  per-checker error count
- i_bit_count  in  3*CntWidth  per-checker bit count
- o_rst_bert  out  1  BERT reset
- o_cfg_ber_count_en  out  WayWidth  count enable to BERT
- o_chk_sel  out  2  active checker index (0..2)
- o_busy  out  1  sequence in progress
- o_done  out  1  sticky; sequence completed
- o_aborted  out  1  sticky; last sequence aborted
- o_status  out  6  2 bits per checker: 00 not run, 01 pass, 10 shutoff, 11 seed timeout
- o_ber_count_lat  out  3*CntWidth  latched error counts
- o_bit_count_lat  out  3*CntWidth  latched bit counts

Behaviour:
- Reset values: all outputs 0; state IDLE; start edge detector history = 0.
- States and transitions:
  - IDLE: on a start rising edge (registered edge detect) and abort low:
    - clear done, aborted, status, and latched counts;
    - select the lowest enabled checker and go to RST;
    - if the mask is 0, go directly to DONE.
  - RST: o_rst_bert=1 for exactly RstCycles cycles, then SEED.
  - SEED: o_rst_bert=0, count_en=0, timeout counter increments each cycle.
    - (seed_good[sel] & way_en) == way_en → COUNT. Seed-good wins over timeout when both occur in the same cycle.
    - Counter reaches i_cfg_seed_timeout → status[sel]=11, then NEXT with no latch.
    - way_en = 0 locks immediately (→ COUNT on the first SEED cycle).
  - COUNT: o_cfg_ber_count_en = i_cfg_way_en; window counter increments.
    - i_ber_shutoff[sel] → status=10, then SETTLE.
    - Window counter == max(meas_len,1) → status=01, then SETTLE.
    - Shutoff wins when both occur in the same cycle.
    - COUNT lasts exactly max(meas_len,1) cycles unless shut off.
  - SETTLE: count_en=0 for SettleCycles cycles, then LATCH.
  - LATCH: one cycle; copy i_ber_count/i_bit_count slices for sel into the latched outputs, then NEXT.
  - NEXT: one cycle; pick the next higher enabled checker → RST; if none remain → DONE.
  - DONE: o_done=1, o_busy=0, return to IDLE in the same cycle (done stays sticky).
- o_busy=1 in every state except IDLE/DONE. o_chk_sel holds its value after the sequence ends.
- Config inputs are sampled live; software must not change them while busy. Only i_cfg_chk_mask is captured at start.
- Start edge while busy: ignored. The edge detector keeps running, so a start held high does not retrigger.
- Abort (any non-IDLE state) takes effect next cycle:
  - state goes to IDLE; o_rst_bert=0, count_en=0, busy=0;
  - o_aborted=1, o_done stays 0;
  - statuses and latched counts of already-completed checkers are kept.
- Abort high in IDLE blocks start.
- Async reset mid-sequence: all outputs return to 0 immediately.
- Counters saturate; the window counter is CntWidth bits and the seed counter is 16 bits.
- No arithmetic on the BERT counts; they are pass-through latched.

Test Plan:
- mask=111, way_en=FFFF, seed_good all high, meas_len=100, no shutoff, counts 5/100 per checker → three RST/SEED/COUNT passes; each count_en window exactly 100 cycles; status=010101; latched counts match; done=1.
- mask=010, seed_good[PRBS15] never high, timeout=50 → SEED lasts 50 cycles; status=001100; latched counts 0; done=1; o_rst_bert pulses once, 4 cycles.
- mask=001, meas_len=1000, shutoff asserted at COUNT cycle 10 → count_en drops after 10 cycles; status[1:0]=10; latch occurs 2 cycles after SETTLE entry.
- mask=101, abort raised in PRBS31 COUNT → next cycle busy=0, count_en=0, aborted=1, done=0, status[1:0]=01 retained.
- mask=000 → done within 2 cycles of start edge, status=000000; second edge while busy in a mask=111 run is ignored (one sequence only).
- meas_len=0 → COUNT lasts 1 cycle; shutoff and window end in same cycle → status 10.
